// File: rtl/adc_channel_scheduler_pkg.sv
// Shared types and helpers for the dual-slope ADC channel scheduler.
package adc_channel_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_INTEGRATE,
    S_DEINT,
    S_STORE
  } state_t;

  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // First set mask bit strictly after 'last', wrapping modulo n; holds 'last' if none.
  function automatic logic [3:0] next_ch(input logic [15:0] mask, input logic [3:0] last,
                                         input int unsigned n);
    logic [3:0]  r;
    logic        found;
    int unsigned idx;
    r     = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= 16; i++) begin
      idx = (int'(last) + i) % n;
      if (!found && i <= n && mask[idx[3:0]]) begin
        r     = idx[3:0];
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; clears to 0 on reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end

endmodule

// File: rtl/adc_channel_scheduler.sv
// Round-robin sequencer sharing one dual-slope integrator across NUM_CH inputs.
module adc_channel_scheduler
  import adc_channel_scheduler_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int CH_W          = 1,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic                    is_neg_v,
  output logic [CH_W-1:0]         mux_sel,
  output logic                    int_dump,
  output logic                    select_v_ref,
  output logic                    busy,
  output logic                    result_valid,
  output logic [CH_W-1:0]         result_ch,
  output logic [CNT_W-1:0]        result_data,
  output logic                    overrange,
  output logic [NUM_CH*CNT_W-1:0] ch_data
);

  localparam logic [CNT_W-1:0] MAX      = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t                         state;
  logic [CNT_W-1:0]               cnt;
  logic [CH_W-1:0]                cur_ch;
  logic [CH_W-1:0]                ptr;
  logic [NUM_CH-1:0][CNT_W-1:0]   ch_reg;
  logic                           neg_s;
  logic                           start;
  logic [CH_W-1:0]                nxt;

  sync_2ff #(.W(1)) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (is_neg_v),
    .q    (neg_s)
  );

  assign start   = enable && (|ch_mask);
  assign nxt     = CH_W'(next_ch(16'(ch_mask), 4'(ptr), NUM_CH));
  assign ch_data = ch_reg;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cur_ch       <= '0;
      ptr          <= '0;
      mux_sel      <= '0;
      int_dump     <= 1'b1;
      select_v_ref <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_ch    <= '0;
      result_data  <= '0;
      overrange    <= 1'b0;
      ch_reg       <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE, S_STORE: begin
          // STORE chains straight into the next conversion when still enabled
          if (start) begin
            cur_ch  <= nxt;
            mux_sel <= nxt;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= S_SETTLE;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_SETTLE:
          if (cnt == SET_LAST) begin
            cnt      <= '0;
            int_dump <= 1'b0;
            state    <= S_INTEGRATE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        S_INTEGRATE: begin
          cnt <= cnt + 1'b1;
          if (cnt == MAX) begin
            select_v_ref <= 1'b1;
            state        <= S_DEINT;
          end
        end
        S_DEINT:
          // On timeout cnt is MAX, so the stored value is MAX with neg_s still high
          if (!neg_s || cnt == MAX) begin
            select_v_ref   <= 1'b0;
            int_dump       <= 1'b1;
            result_valid   <= 1'b1;
            result_ch      <= cur_ch;
            result_data    <= cnt;
            overrange      <= neg_s;
            ch_reg[cur_ch] <= cnt;
            ptr            <= cur_ch;
            state          <= S_STORE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end

endmodule

// File: tb/tb_adc_channel_scheduler.sv
// Directed bench for adc_channel_scheduler at default parameters.
module tb_adc_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  ch_mask;
  logic        is_neg_v;
  logic [0:0]  mux_sel;
  logic        int_dump;
  logic        select_v_ref;
  logic        busy;
  logic        result_valid;
  logic [0:0]  result_ch;
  logic [7:0]  result_data;
  logic        overrange;
  logic [15:0] ch_data;

  int errors = 0;
  int checks = 0;

  adc_channel_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ch_mask     (ch_mask),
    .is_neg_v    (is_neg_v),
    .mux_sel     (mux_sel),
    .int_dump    (int_dump),
    .select_v_ref(select_v_ref),
    .busy        (busy),
    .result_valid(result_valid),
    .result_ch   (result_ch),
    .result_data (result_data),
    .overrange   (overrange),
    .ch_data     (ch_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_sel();
    int n = 0;
    @(negedge clk);
    while (!select_v_ref && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_select_v_ref", select_v_ref, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 2000);
    chk("wait_result_valid", result_valid, 1);
  endtask

  // Comparator crosses d cycles into DEINT; synchronizer adds 2 more.
  task automatic convert_meas(input string tag, input int d, input int ch);
    int n;
    is_neg_v = 1'b1;
    wait_sel();
    repeat (d) @(negedge clk);
    is_neg_v = 1'b0;
    wait_valid(n);
    chk({tag, "_ch"},   result_ch, ch);
    chk({tag, "_mux"},  mux_sel, ch);
    chk({tag, "_data"}, result_data, d + 2);
    chk({tag, "_ovr"},  overrange, 0);
  endtask

  initial begin
    int n, nsel;

    reset    = 1'b0;
    enable   = 1'b1;
    ch_mask  = 2'b01;
    is_neg_v = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_int_dump", int_dump, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sel_ref", select_v_ref, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_mux", mux_sel, 0);
    chk("rst_res", {result_ch, overrange, result_data}, 0);
    chk("rst_ch_data", ch_data, 0);

    // zero input: conversion is 16 + 256 + 1 + 1 cycles, ref phase one cycle
    reset = 1'b1;
    n = 0;
    nsel = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("zero_busy_rise", busy, 1);
      if (select_v_ref) nsel++;
    end while (!result_valid && n < 2000);
    chk("zero_latency", n, 16 + 256 + 1 + 1);
    chk("zero_sel_cycles", nsel, 1);
    chk("zero_ch", result_ch, 0);
    chk("zero_data", result_data, 0);
    chk("zero_ovr", overrange, 0);
    is_neg_v = 1'b1;
    @(negedge clk);
    chk("valid_pulse_width", result_valid, 0);

    convert_meas("meas102", 100, 0);
    chk("meas102_ch_data", ch_data[7:0], 102);

    // overrange: comparator never trips, DEINT runs its full 256 cycles
    is_neg_v = 1'b1;
    wait_sel();
    nsel = 0;
    while (select_v_ref && nsel < 1000) begin
      nsel++;
      @(negedge clk);
    end
    chk("ovr_deint_len", nsel, 256);
    chk("ovr_valid", result_valid, 1);
    chk("ovr_data", result_data, 255);
    chk("ovr_flag", overrange, 1);
    chk("ovr_ch_data", ch_data[7:0], 255);

    ch_mask = 2'b10;
    convert_meas("ch1only", 40, 1);
    chk("ch1only_ch_data", ch_data, 16'h2AFF);

    ch_mask = 2'b11;
    convert_meas("rr0", 10, 0);
    convert_meas("rr1", 20, 1);
    convert_meas("rr2", 30, 0);
    convert_meas("rr3", 50, 1);
    chk("rr_ch_data", ch_data, 16'h3420);

    // mask narrowed while ch0 is integrating
    repeat (50) @(negedge clk);
    ch_mask = 2'b10;
    convert_meas("mask_ch0", 5, 0);
    convert_meas("mask_ch1a", 6, 1);
    convert_meas("mask_ch1b", 7, 1);

    // enable dropped mid-INTEGRATE: finishes, stores, then idles
    repeat (100) @(negedge clk);
    enable = 1'b0;
    convert_meas("stop", 3, 1);
    @(negedge clk);
    chk("stop_busy", busy, 0);
    repeat (20) @(negedge clk);
    chk("stop_stay_idle", busy, 0);
    chk("stop_int_dump", int_dump, 1);
    chk("stop_ch_data", ch_data, 16'h0507);

    // async reset in the middle of DEINT, checked before the next clock edge
    enable   = 1'b1;
    ch_mask  = 2'b01;
    is_neg_v = 1'b1;
    wait_sel();
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_sel_ref", select_v_ref, 0);
    chk("areset_int_dump", int_dump, 1);
    chk("areset_busy", busy, 0);
    chk("areset_ch_data", ch_data, 0);
    chk("areset_res", {mux_sel, result_ch, overrange, result_data}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_channel_scheduler.md
Name: adc_channel_scheduler

Overview:
Sequencer that time-shares one dual-slope integrator/comparator front end between NUM_CH analog inputs, for example the two paddle potentiometers. It selects the channel on the analog mux and discharges the integrator. It then runs the fixed integrate phase and the reference de-integrate phase, measures the de-integrate time, and stores one result per channel. Channels are serviced round-robin. It sits between the analog front end and the game logic, which reads results from ch_data.

Parameters:
- NUM_CH, 2: number of analog channels; range 1..16.
- CH_W, 1: channel index width; must satisfy ceil(log2(NUM_CH)), minimum 1.
- CNT_W, 8: counter and result width; integrate phase lasts 2^CNT_W cycles.
- SETTLE_CYCLES, 16: cycles spent in the SETTLE state; minimum 1.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: run continuous round-robin conversions.
- ch_mask, input, NUM_CH: bit i=1 includes channel i in the rotation.
- is_neg_v, input, 1: comparator output, asynchronous; 1 while the integrator is below threshold.
- mux_sel, output, CH_W: analog mux channel select.
- int_dump, output, 1: 1 shorts the integrator capacitor.
- select_v_ref, output, 1: 0 selects the input signal, 1 selects the reference.
- busy, output, 1: 1 in any state other than IDLE.
- result_valid, output, 1: one-cycle pulse when a result is stored.
- result_ch, output, CH_W: channel of the latest result.
- result_data, output, CNT_W: latest result.
- overrange, output, 1: flag of the latest result; 1 = de-integrate timed out.
- ch_data, output, NUM_CH*CNT_W: per-channel result registers; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets all outputs to 0 except int_dump=1.
  - ch_data, the round-robin pointer and the synchronizer flops are all cleared.
  - The state goes to IDLE.
- is_neg_v passes through a 2-flop synchronizer; neg_s is its output.
  - The 2-cycle delay is not compensated; it is part of the result.
- States: IDLE, SETTLE, INTEGRATE, DEINT, STORE.
- IDLE:
  - Outputs: int_dump=1, select_v_ref=0.
  - If enable=1 and ch_mask!=0: choose the next channel with its mask bit set, searching upward from last+1 and wrapping modulo NUM_CH.
  - Load that channel into mux_sel, clear the counter, go to SETTLE.
  - ch_mask is sampled only at this selection point.
- SETTLE:
  - Outputs: int_dump=1, select_v_ref=0.
  - Lasts exactly SETTLE_CYCLES cycles, then clears the counter and goes to INTEGRATE.
- INTEGRATE:
  - Outputs: int_dump=0, select_v_ref=0.
  - Lasts exactly 2^CNT_W cycles; the counter runs 0 to max, then wraps to 0.
  - Then go to DEINT.
- DEINT:
  - Output: select_v_ref=1.
  - On each cycle with counter value k:
    - If neg_s=0: result=k, overrange=0, go to STORE.
    - Else if k=max: result=max, overrange=1, go to STORE.
    - Else: counter increments.
- STORE (1 cycle):
  - Outputs: int_dump=1, select_v_ref=0.
  - Drive result_valid=1 and update result_ch, result_data, overrange and ch_data[ch]; the pointer becomes ch.
  - Next state: if enable=1 and ch_mask!=0, select the next channel as in IDLE and go directly to SETTLE; otherwise go to IDLE.
- enable=0 mid-conversion: the current conversion completes and stores, then the block goes to IDLE.
- Skipped (masked) channels keep their previous ch_data values.
- If only one mask bit is set, that channel is converted repeatedly.
- Conversion time = SETTLE_CYCLES + 2^CNT_W + (k+1) + 1 cycles; the +1 is STORE.
- result_data, result_ch and overrange hold their values until the next STORE.

Decomposition:
- Shared package contains:
  - State encoding enum.
  - Counter max constant: (1<<CNT_W)-1.
  - Helper function for next set mask bit after a given index.
- One natural sub-module: sync_2ff, the comparator synchronizer, reusable for other asynchronous inputs.
- Channel selection and the FSM stay in the top module.

Test Plan:
All scenarios use the default parameters.
- Reset: hold reset=0 for 5 cycles, with enable=1 -> int_dump=1, all other outputs 0, busy=0, ch_data=0.
- Single channel, zero input: ch_mask=2'b01, enable=1, is_neg_v=0 constant.
  - Required: result_valid pulses with ch=0, data=0, overrange=0.
  - Pulse occurs 16+256+1+1 cycles after leaving IDLE.
  - select_v_ref is high for exactly 1 cycle.
- Measured value: comparator model drops is_neg_v 100 cycles after select_v_ref rises.
  - Required: data=102 (2-cycle synchronizer delay) and ch_data[7:0]=102.
- Overrange: is_neg_v=1 constant.
  - Required: DEINT lasts 256 cycles, then data=255, overrange=1.
- Round-robin: ch_mask=2'b11, 4 conversions -> mux_sel/result_ch sequence 0,1,0,1.
  - Mask 2'b10 applied mid-conversion of ch0 -> ch0 completes, then only ch1 is converted.
- Stop and async reset:
  - enable dropped mid-INTEGRATE -> the conversion stores, then busy=0 and the block stays in IDLE.
  - reset asserted mid-DEINT -> outputs clear immediately, without waiting for a clock edge.
